// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM arbiter: tile-map geometry,
// RAM widths and the writer identifiers used by the round-robin arbiter.
package vram_pkg;

    localparam int MAP_W      = 40;   // tiles per row
    localparam int MAP_H      = 30;   // tile rows
    localparam int TILE_SHIFT = 4;    // 16x16 pixel tiles
    localparam int AW         = 11;   // RAM address width
    localparam int DW         = 4;    // tile code width

    localparam int MAP_SIZE   = MAP_W * MAP_H;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_t;

endpackage

// File: rtl/vram_arbiter_rr.sv
// rr_arbiter2: two-input round-robin arbiter. gnt is combinational and
// one-hot (or zero); last_grant remembers the most recent winner so that a
// tie goes to the other writer. Resets to GNT_B so A wins the first tie.
module rr_arbiter2
    import vram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt,
    output grant_t     last_grant
);

    // Pick a winner among the requesting writers when the slot allows it.
    always_comb begin
        // NOTE: gnt gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_grant == GNT_A) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Remember the writer that was granted most recently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GNT_B;
        end else if (gnt[0]) begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            last_grant <= GNT_A;
        end else if (gnt[1]) begin
            last_grant <= GNT_B;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous tile RAM between the VGA
// display read path and two writers (A: robot, B: pipe map updates).
// Display reads own every p_tick slot during active video; writers are
// round-robin arbitrated on the remaining cycles.
// Build option: define VRAM_BLANK_WR_EN to allow writes only while
// video_on=0 (no mid-frame tearing); undefined, writes use any non-display
// cycle.
module vram_arbiter
    import vram_pkg::*;
(
    input  logic          clock_25,
    input  logic          reset_key,
    input  logic [9:0]    pixel_x,
    input  logic [9:0]    pixel_y,
    input  logic          video_on,
    input  logic          p_tick,
    input  logic          req_a,
    input  logic          req_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] data_a,
    input  logic [DW-1:0] data_b,
    output logic          ack_a,
    output logic          ack_b,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] disp_tile,
    output logic          disp_valid,
    output logic          wr_err
);

    logic          disp_slot;
    logic          wr_enable;
    logic [1:0]    req_eff;
    logic [1:0]    gnt;
    grant_t        last_grant;
    logic [AW-1:0] tile_addr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          in_range;
    logic          rd_p1;
    logic          rd_p2;

    // Slot decoder: display owns p_tick cycles inside the active region.
    assign disp_slot = p_tick & video_on;

`ifdef VRAM_BLANK_WR_EN
    assign wr_enable = ~disp_slot & ~video_on;
`else
    assign wr_enable = ~disp_slot;
`endif

    // A writer still holds req during its ack cycle; masking it there keeps
    // one request from being granted twice.
    assign req_eff = {req_b & ~ack_b, req_a & ~ack_a};

    rr_arbiter2 u_rr (
        .clk        (clock_25),
        .rst_n      (reset_key),
        .req        (req_eff),
        .enable     (wr_enable),
        .gnt        (gnt),
        .last_grant (last_grant)
    );

    // Tile index of the current pixel, row-major, truncated to AW bits.
    assign tile_addr = AW'(AW'(pixel_y >> TILE_SHIFT) * AW'(MAP_W)
                         + AW'(pixel_x >> TILE_SHIFT));

    assign sel_addr = gnt[1] ? addr_b : addr_a;
    assign sel_data = gnt[1] ? data_b : data_a;
    assign in_range = (sel_addr < AW'(MAP_SIZE));

    // RAM port: display address on DISP slots, granted write otherwise.
    always_ff @(posedge clock_25 or negedge reset_key) begin
        if (!reset_key) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            ack_a  <= gnt[0];
            ack_b  <= gnt[1];
            if (disp_slot) begin
                mem_addr <= tile_addr;
            end else if (|gnt) begin
                if (in_range) begin
                    mem_addr  <= sel_addr;
                    mem_wdata <= sel_data;
                    mem_we    <= 1'b1;
                end else begin
                    wr_err <= 1'b1;
                end
            end
        end
    end

    // Read pipeline: address issued, RAM data returns, tile captured.
    always_ff @(posedge clock_25 or negedge reset_key) begin
        if (!reset_key) begin
            rd_p1      <= 1'b0;
            rd_p2      <= 1'b0;
            disp_valid <= 1'b0;
            disp_tile  <= '0;
        end else begin
            rd_p1      <= disp_slot;
            rd_p2      <= rd_p1;
            disp_valid <= rd_p2;
            if (rd_p2) begin
                disp_tile <= mem_rdata;
            end
        end
    end

    // The two acknowledges are mutually exclusive.
    a_one_ack: assert property (@(posedge clock_25) disable iff (!reset_key)
                                !(ack_a && ack_b));

    // A display slot never disturbs the round-robin history.
    a_disp_keeps_rr: assert property (@(posedge clock_25) disable iff (!reset_key)
                                      disp_slot |=> $stable(last_grant));

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter. A behavioural synchronous RAM sits
// on the memory port; expected writes and display tiles are queued when the
// stimulus is driven and compared when the DUT acks or raises disp_valid.
`timescale 1ns/1ps
module tb_vram_arbiter;
    import vram_pkg::*;

    logic          clock_25  = 1'b0;
    logic          reset_key = 1'b0;
    logic [9:0]    pixel_x   = '0;
    logic [9:0]    pixel_y   = '0;
    logic          video_on  = 1'b0;
    logic          p_tick    = 1'b0;
    logic          req_a     = 1'b0;
    logic          req_b     = 1'b0;
    logic [AW-1:0] addr_a    = '0;
    logic [AW-1:0] addr_b    = '0;
    logic [DW-1:0] data_a    = '0;
    logic [DW-1:0] data_b    = '0;
    logic          ack_a, ack_b, mem_we, disp_valid, wr_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, disp_tile;
    logic [DW-1:0] mem_rdata = '0;

    always #20 clock_25 = ~clock_25;

    vram_arbiter dut (
        .clock_25   (clock_25),
        .reset_key  (reset_key),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .p_tick     (p_tick),
        .req_a      (req_a),
        .req_b      (req_b),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .data_a     (data_a),
        .data_b     (data_b),
        .ack_a      (ack_a),
        .ack_b      (ack_b),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .disp_tile  (disp_tile),
        .disp_valid (disp_valid),
        .wr_err     (wr_err)
    );

    // Behavioural single-port RAM with a bench-side preload port.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          pre_we   = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clock_25) begin
        if (pre_we)
            ram[pre_addr] <= pre_data;
        else if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct packed {
        logic          is_b;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          we;
    } wr_exp_t;

    wr_exp_t       wr_q[$];
    logic [DW-1:0] disp_q[$];
    wr_exp_t       mon_e;
    logic [DW-1:0] mon_t;
    int            n_checks = 0;
    int            n_fail   = 0;

    // Scoreboard: pop and compare whenever the DUT acks or delivers a tile.
    always @(posedge clock_25) begin
        #2;
        if (ack_a || ack_b) begin
            n_checks++;
            if (ack_a && ack_b) begin
                n_fail++;
                $display("FAIL both_acks: ack_a=%0b ack_b=%0b, required at most one", ack_a, ack_b);
            end else if (wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack: ack_a=%0b ack_b=%0b addr=%0d, required no ack", ack_a, ack_b, mem_addr);
            end else begin
                mon_e = wr_q.pop_front();
                if (ack_b !== mon_e.is_b || mem_we !== mon_e.we ||
                    (mon_e.we && (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data))) begin
                    n_fail++;
                    $display("FAIL write_port: ack_b=%0b we=%0b addr=%0d data=%0h, required ack_b=%0b we=%0b addr=%0d data=%0h",
                             ack_b, mem_we, mem_addr, mem_wdata, mon_e.is_b, mon_e.we, mon_e.addr, mon_e.data);
                end
            end
        end else if (mem_we) begin
            n_checks++;
            n_fail++;
            $display("FAIL write_without_ack: mem_we=1 addr=%0d, required mem_we=0", mem_addr);
        end
        if (disp_valid) begin
            n_checks++;
            if (disp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_disp_valid: disp_tile=%0h, required no disp_valid", disp_tile);
            end else begin
                mon_t = disp_q.pop_front();
                if (disp_tile !== mon_t) begin
                    n_fail++;
                    $display("FAIL disp_tile: got %0h, required %0h", disp_tile, mon_t);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock_25);
        #1;
    endtask

    task automatic set_idle();
        req_a = 1'b0; req_b = 1'b0;
        video_on = 1'b0; p_tick = 1'b0;
        pixel_x = '0; pixel_y = '0;
    endtask

    task automatic do_reset();
        set_idle();
        reset_key = 1'b0;
        tick();
        tick();
        reset_key = 1'b1;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (wr_q.size() == 0 && disp_q.size() == 0) break;
            tick();
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        set_idle();
        reset_key = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({ack_a, ack_b, mem_we, disp_valid, wr_err} !== 5'b0 || mem_addr !== '0 ||
            mem_wdata !== '0 || disp_tile !== '0) begin
            n_fail++;
            $display("FAIL reset_values: acks=%0b%0b we=%0b dv=%0b err=%0b addr=%0d wd=%0h tile=%0h, required all 0",
                     ack_a, ack_b, mem_we, disp_valid, wr_err, mem_addr, mem_wdata, disp_tile);
        end
        reset_key = 1'b1;
        tick();
        // Start a read, then reset while it is in flight.
        video_on = 1'b1; p_tick = 1'b1; pixel_x = 10'd33; pixel_y = 10'd20;
        req_a = 1'b1; addr_a = 11'd100; data_a = 4'h6;
        tick();
        n_checks++;
        if (mem_addr !== 11'd42) begin
            n_fail++;
            $display("FAIL pre_reset_read_addr: got %0d, required 42", mem_addr);
        end
        video_on = 1'b0; p_tick = 1'b0;
        #4;
        reset_key = 1'b0;
        #1;
        n_checks++;
        if (mem_addr !== '0 || mem_we !== 1'b0 || ack_a !== 1'b0 || disp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: addr=%0d we=%0b ack_a=%0b dv=%0b, required all 0",
                     mem_addr, mem_we, ack_a, disp_valid);
        end
        tick();
        tick();
        req_a = 1'b0;
        reset_key = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (disp_valid === 1'b1 || ack_a === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_discard: disp_valid/ack seen=1 after reset, required 0");
        end
        // First tie after reset goes to A.
        req_a = 1'b1; addr_a = 11'd100; data_a = 4'h6;
        req_b = 1'b1; addr_b = 11'd101; data_b = 4'h9;
        wr_q.push_back('{is_b: 1'b0, addr: 11'd100, data: 4'h6, we: 1'b1});
        tick();
        n_checks++;
        if (ack_a !== 1'b1 || ack_b !== 1'b0) begin
            n_fail++;
            $display("FAIL first_tie: ack_a=%0b ack_b=%0b, required ack_a=1 ack_b=0", ack_a, ack_b);
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_disp_read();
        logic [9:0]    tx [3] = '{10'd0, 10'd639, 10'd160};
        logic [9:0]    ty [3] = '{10'd0, 10'd479, 10'd100};
        logic [AW-1:0] ta [3] = '{11'd0, 11'd1199, 11'd250};
        logic [DW-1:0] tt [3] = '{4'h5, 4'hA, 4'hC};
        do_reset();
        video_on = 1'b1; p_tick = 1'b1; pixel_x = 10'd33; pixel_y = 10'd20;
        disp_q.push_back(4'h7);
        tick();
        n_checks++;
        if (mem_addr !== 11'd42 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL disp_addr: addr=%0d we=%0b, required addr=42 we=0", mem_addr, mem_we);
        end
        video_on = 1'b0; p_tick = 1'b0;
        tick();
        n_checks++;
        if (disp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL disp_latency_early: disp_valid=%0b one clock after slot, required 0", disp_valid);
        end
        tick();
        n_checks++;
        if (disp_valid !== 1'b1 || disp_tile !== 4'h7) begin
            n_fail++;
            $display("FAIL disp_latency: disp_valid=%0b tile=%0h two clocks after slot, required 1 and 7",
                     disp_valid, disp_tile);
        end
        // Back-to-back reads including the last tile of the map.
        for (int i = 0; i < 3; i++) begin
            video_on = 1'b1; p_tick = 1'b1; pixel_x = tx[i]; pixel_y = ty[i];
            disp_q.push_back(tt[i]);
            tick();
            n_checks++;
            if (mem_addr !== ta[i]) begin
                n_fail++;
                $display("FAIL disp_addr_%0d: got %0d, required %0d", i, mem_addr, ta[i]);
            end
        end
        set_idle();
        wait_idle(8);
    endtask

    task automatic test_alternate();
        bit exp_b;
        do_reset();
        addr_a = 11'd10; data_a = 4'h1;
        addr_b = 11'd20; data_b = 4'h2;
        req_a = 1'b1; req_b = 1'b1;
        for (int k = 0; k < 6; k++)
            wr_q.push_back('{is_b: k[0], addr: k[0] ? 11'd20 : 11'd10,
                             data: k[0] ? 4'h2 : 4'h1, we: 1'b1});
        for (int k = 0; k < 6; k++) begin
            exp_b = k[0];
            tick();
            n_checks++;
            if (ack_a !== !exp_b || ack_b !== exp_b || mem_we !== 1'b1) begin
                n_fail++;
                $display("FAIL alternate_%0d: ack_a=%0b ack_b=%0b we=%0b, required ack_a=%0b ack_b=%0b we=1",
                         k, ack_a, ack_b, mem_we, !exp_b, exp_b);
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        wait_idle(4);
        tick();
    endtask

    task automatic test_range();
        do_reset();
        req_b = 1'b1; addr_b = 11'd1200; data_b = 4'h9;
        wr_q.push_back('{is_b: 1'b1, addr: 11'd1200, data: 4'h9, we: 1'b0});
        tick();
        n_checks++;
        if (ack_b !== 1'b1 || mem_we !== 1'b0 || wr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL range_drop: ack_b=%0b we=%0b wr_err=%0b, required ack_b=1 we=0 wr_err=1",
                     ack_b, mem_we, wr_err);
        end
        req_b = 1'b0;
        req_a = 1'b1; addr_a = 11'd1199; data_a = 4'h2;
        wr_q.push_back('{is_b: 1'b0, addr: 11'd1199, data: 4'h2, we: 1'b1});
        tick();
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 11'd1199) begin
            n_fail++;
            $display("FAIL range_last_tile: we=%0b addr=%0d, required we=1 addr=1199", mem_we, mem_addr);
        end
        req_a = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (wr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_err_sticky: got %0b, required 1", wr_err);
        end
        do_reset();
        n_checks++;
        if (wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_err_reset: got %0b, required 0", wr_err);
        end
    endtask

`ifndef VRAM_BLANK_WR_EN
    task automatic test_video_write();
        bit prev_tick;
        bit got;
        do_reset();
        video_on = 1'b1; pixel_y = 10'd32;
        req_a = 1'b1; addr_a = 11'd5; data_a = 4'h3;
        wr_q.push_back('{is_b: 1'b0, addr: 11'd5, data: 4'h3, we: 1'b1});
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            p_tick  = (k % 2 == 0);
            pixel_x = 10'(16 * k);
            if (p_tick) disp_q.push_back(4'((k + 1) & 15));
            prev_tick = p_tick;
            tick();
            if (ack_a === 1'b1) begin
                got = 1'b1;
                n_checks++;
                if (prev_tick !== 1'b0 || mem_addr !== 11'd5 || mem_wdata !== 4'h3) begin
                    n_fail++;
                    $display("FAIL video_ack_slot: p_tick=%0b addr=%0d data=%0h, required p_tick=0 addr=5 data=3",
                             prev_tick, mem_addr, mem_wdata);
                end
                req_a = 1'b0;
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL video_ack_seen: no ack_a within 10 clocks, required one");
        end
        set_idle();
        wait_idle(6);
        // Read back the written tile through the display path.
        video_on = 1'b1; p_tick = 1'b1; pixel_x = 10'd80; pixel_y = 10'd0;
        disp_q.push_back(4'h3);
        tick();
        set_idle();
        wait_idle(6);
    endtask

    task automatic test_video_both();
        int acks;
        int wait_a;
        int wait_b;
        do_reset();
        video_on = 1'b1; pixel_y = 10'd32;
        req_a = 1'b1; addr_a = 11'd30; data_a = 4'hD;
        req_b = 1'b1; addr_b = 11'd31; data_b = 4'hE;
        for (int k = 0; k < 4; k++)
            wr_q.push_back('{is_b: k[0], addr: k[0] ? 11'd31 : 11'd30,
                             data: k[0] ? 4'hE : 4'hD, we: 1'b1});
        acks = 0; wait_a = 0; wait_b = 0;
        for (int k = 0; k < 12; k++) begin
            p_tick  = (k % 2 == 0);
            pixel_x = 10'(16 * k);
            if (p_tick) disp_q.push_back(4'((k + 1) & 15));
            tick();
            if (req_a) wait_a++;
            if (req_b) wait_b++;
            if (ack_a === 1'b1 || ack_b === 1'b1) begin
                acks++;
                n_checks++;
                if ((ack_a === 1'b1 && wait_a > 4) || (ack_b === 1'b1 && wait_b > 4)) begin
                    n_fail++;
                    $display("FAIL wait_bound: wait_a=%0d wait_b=%0d, required at most 4", wait_a, wait_b);
                end
                if (ack_a === 1'b1) wait_a = 0;
                if (ack_b === 1'b1) wait_b = 0;
                if (acks == 4) begin
                    req_a = 1'b0; req_b = 1'b0;
                end
            end
        end
        n_checks++;
        if (acks != 4) begin
            n_fail++;
            $display("FAIL video_both_count: got %0d acks, required 4", acks);
        end
        set_idle();
        wait_idle(6);
    endtask
`else
    task automatic test_blank();
        bit early;
        do_reset();
        video_on = 1'b1; pixel_y = 10'd32;
        req_a = 1'b1; addr_a = 11'd7; data_a = 4'h8;
        early = 1'b0;
        for (int k = 0; k < 8; k++) begin
            p_tick  = (k % 2 == 0);
            pixel_x = 10'(16 * k);
            if (p_tick) disp_q.push_back(4'((k + 1) & 15));
            tick();
            if (ack_a !== 1'b0) early = 1'b1;
        end
        n_checks++;
        if (early) begin
            n_fail++;
            $display("FAIL blank_hold: ack_a seen during active video, required none");
        end
        video_on = 1'b0; p_tick = 1'b0;
        wr_q.push_back('{is_b: 1'b0, addr: 11'd7, data: 4'h8, we: 1'b1});
        tick();
        n_checks++;
        if (ack_a !== 1'b1 || mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL blank_ack: ack_a=%0b we=%0b on first blank cycle, required 1 and 1", ack_a, mem_we);
        end
        set_idle();
        wait_idle(6);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        preload(11'd42, 4'h7);
        preload(11'd0, 4'h5);
        preload(11'd1199, 4'hA);
        preload(11'd250, 4'hC);
        for (int k = 0; k < 16; k++) preload(11'(80 + k), 4'((k + 1) & 15));

        test_reset();
        test_disp_read();
        test_alternate();
        test_range();
`ifndef VRAM_BLANK_WR_EN
        test_video_write();
        test_video_both();
`else
        test_blank();
`endif
        wait_idle(8);
        n_checks++;
        if (wr_q.size() != 0 || disp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expectations: %0d writes %0d tiles outstanding, required 0 and 0",
                     wr_q.size(), disp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
